// File: rtl/gate_bist_if.sv
// Signal bundle between gate_bist and its requester / gate under test.
// Handshake: a run is requested by holding start high while busy is low; busy rises on the
// accepting edge, and done pulses for exactly one cycle as busy falls, with pass/err/fails valid from then on.
interface gate_bist_if;
  logic       start;
  logic       y;
  logic       a;
  logic       busy;
  logic       done;
  logic       pass;
  logic [1:0] err;
  logic [7:0] fails;
  logic [1:0] fsm_state;

  modport master (
    output start, y,
    input  a, busy, done, pass, err, fails, fsm_state
  );

  modport slave (
    input  start, y,
    output a, busy, done, pass, err, fails, fsm_state
  );
endinterface

// File: rtl/gate_bist.sv
// BIST sequencer for a single-input gate: drives a=0 then a=1, samples y after a settle wait.
// Optional macro GATE_BIST_SYNC_EN inserts a two-flop synchronizer on y and adds 2 to the wait.
module gate_bist #(
  parameter int   SETTLE = 2,
  parameter logic EXP0   = 1'b1,
  parameter logic EXP1   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  gate_bist_if.slave bus
);

`ifdef GATE_BIST_SYNC_EN
  localparam int W     = SETTLE + 2;
  localparam int CNT_W = 9;

  logic [1:0] sync_q;
  logic       y_cmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], bus.y};
  end
  assign y_cmp = sync_q[1];
`else
  localparam int W     = SETTLE;
  localparam int CNT_W = 8;

  logic y_cmp;
  assign y_cmp = bus.y;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             a_q, a_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             pass_q, pass_n;
  logic [1:0]       err_q, err_n;
  logic             pend0_q, pend0_n;
  logic [7:0]       fails_q, fails_n;
  logic             run_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt_q;
    a_n      = a_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    pass_n   = pass_q;
    err_n    = err_q;
    pend0_n  = pend0_q;
    fails_n  = fails_q;
    run_fail = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_n     = 1'b0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = WAIT0;
        end
      end
      WAIT0: begin
        // Vector-0 result is parked so err stays stable until the run finishes.
        if (cnt_q == CNT_LAST) begin
          pend0_n = (y_cmp != EXP0);
          a_n     = 1'b1;
          cnt_n   = '0;
          state_n = WAIT1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      WAIT1: begin
        if (cnt_q == CNT_LAST) begin
          run_fail = (y_cmp != EXP1) | pend0_q;
          err_n    = {(y_cmp != EXP1), pend0_q};
          pass_n   = ~run_fail;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          cnt_n    = '0;
          if (run_fail && fails_q != 8'hFF) fails_n = fails_q + 8'd1;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 2'b00;
      pend0_q <= 1'b0;
      fails_q <= 8'd0;
    end else begin
      cnt_q   <= cnt_n;
      a_q     <= a_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      pass_q  <= pass_n;
      err_q   <= err_n;
      pend0_q <= pend0_n;
      fails_q <= fails_n;
    end
  end

  assign bus.a         = a_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err       = err_q;
  assign bus.fails     = fails_q;
  assign bus.fsm_state = state;

endmodule
